// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch port: one request channel (valid/ready) and one
// single-cycle response pulse channel.
interface pc_fetch_sequencer_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: issues one outstanding imem request at a time, arbitrates
// trap/jump/branch redirects, drops stale responses and feeds the IF/ID slot.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        trap_valid,
  input  logic [31:0]                 trap_target,
  input  logic                        j,
  input  logic [31:0]                 ja,
  input  logic                        br,
  input  logic [31:0]                 bta,
  pc_fetch_sequencer_if.master        imem,
  output logic                        if_valid,
  output logic [31:0]                 if_pc,
  output logic [31:0]                 if_instr
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, KILL} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_instr_reg, if_instr_next;

  logic        redirect;
  logic [31:0] tgt;
  logic        slot_ok;
  logic        req_valid;
  logic        handshake;
  logic        capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= BOOT;
      fetch_pc_reg <= RESET_PC & ~32'h3;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= 32'h0;
      if_instr_reg <= NOP_INSTR;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if_valid_reg <= if_valid_next;
      if_pc_reg    <= if_pc_next;
      if_instr_reg <= if_instr_next;
    end
  end

  always_comb begin
    redirect      = trap_valid | j | br;
    tgt           = (trap_valid ? trap_target : (j ? ja : bta)) & ~32'h3;
    slot_ok       = !if_valid_reg || !stall;
    // Request is masked during any redirect so an unaccepted address only moves on a redirect.
    req_valid     = (state_reg == REQ) && slot_ok && !redirect;
    handshake     = req_valid && imem.imem_req_ready;

    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    capture       = 1'b0;

    case (state_reg)
      BOOT: state_next = REQ;
      REQ: begin
        if (handshake) begin
          fetch_pc_next = fetch_pc_reg + PC_STEP;
          state_next    = WAIT;
        end else if (redirect) begin
          fetch_pc_next = tgt;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_next = tgt;
          state_next    = imem.imem_resp_valid ? REQ : KILL;
        end else if (imem.imem_resp_valid) begin
          capture    = 1'b1;
          state_next = REQ;
        end
      end
      KILL: begin
        // The response still in flight belongs to the old path; latest redirect wins.
        if (redirect) fetch_pc_next = tgt;
        if (imem.imem_resp_valid) state_next = REQ;
      end
      default: state_next = BOOT;
    endcase

    if_valid_next = if_valid_reg;
    if_pc_next    = if_pc_reg;
    if_instr_next = if_instr_reg;
    if (redirect) begin
      if_valid_next = 1'b0;
    end else if (capture) begin
      if_valid_next = 1'b1;
      if_pc_next    = fetch_pc_reg - PC_STEP;
      if_instr_next = imem.imem_resp_data;
    end else if (!stall) begin
      if_valid_next = 1'b0;
    end
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc_reg;
  assign if_valid            = if_valid_reg;
  assign if_pc               = if_pc_reg;
  assign if_instr            = if_instr_reg;

endmodule
